and_share_arb: RTL and testbench
================================

AND_SHARE_ARB -- requirements
Module: and_share_arb

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  4  request lines, one per requester (index 0..3).
REQ-005 a_in  input  4*WIDTH  operand A per requester; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 b_in  input  4*WIDTH  operand B per requester, packed the same way as a_in.
REQ-007 gnt  output  4  one-hot grant pulse identifying the accepted requester.
REQ-008 busy  output  1  high while the shared AND engine is computing.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 done_id  output  2  index of the requester whose result is on y.
REQ-011 y  output  WIDTH  result a & b of the last completed transaction.

Function
REQ-012 The block SHALL contain exactly one 1-bit AND operation, time-shared bit-serially across all requesters and bits.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE with req != 0 at a rising edge:
  - select winner w by round-robin;
  - latch a_in/b_in slice w into internal operand registers;
  - clear the bit counter;
  - register gnt = one-hot(w) for exactly one cycle;
  - go to BUSY.
REQ-015 Round-robin: search starts at (last_w + 1) mod 4 and wraps upward; the first asserted req wins.
REQ-016 IDLE with req == 0: state, gnt, busy and done remain 0, and y holds its value.
REQ-017 BUSY, each cycle:
  - compute bit cnt of the partial result as opA[cnt] & opB[cnt];
  - increment cnt;
  - busy = 1.
REQ-018 BUSY SHALL last exactly WIDTH cycles; at the edge where cnt == WIDTH-1 the state goes to DONE.
REQ-019 On entering DONE:
  - y is loaded with the full partial result;
  - done_id = w;
  - done = 1 for exactly one cycle;
  - busy = 0.
REQ-020 DONE SHALL return to IDLE unconditionally; requests are not accepted in DONE.
REQ-021 Latency: request accepted at edge k → done high during the cycle following edge k+WIDTH; next acceptance no earlier than edge k+WIDTH+2.
REQ-022 y and done_id SHALL hold between done pulses and change only on entry to DONE.
REQ-023 req and operand changes during BUSY/DONE SHALL be ignored; results use the operands latched at acceptance.
REQ-024 A requester still asserting req in IDLE after its grant SHALL be treated as a new request, subject to round-robin.
REQ-025 Simultaneous requests SHALL yield exactly one gnt bit; losers stay pending and are not dropped, provided they keep req asserted.
REQ-026 gnt SHALL never have more than one bit set; gnt, busy and done SHALL be mutually exclusive in any cycle, except that gnt and busy are both high in the first BUSY cycle.

Reset
REQ-027 rst_n low SHALL immediately force:
  - state IDLE;
  - gnt = 0, busy = 0, done = 0;
  - done_id = 0, y = 0;
  - cnt = 0;
  - last_w = 3, so requester 0 has first priority.
REQ-028 Reset asserted mid-BUSY SHALL abort the transaction with no done pulse; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-029 Single request, WIDTH=8: req=0001, A0=0xF0, B0=0x3C → gnt=0001 for 1 cycle, busy high for 8 cycles, then done=1, done_id=0, y=0x30.
REQ-030 All four requesting continuously, distinct operands → grant order 0,1,2,3,0; each done_id matches and each y equals that requester's A&B; done pulses are spaced WIDTH+2 cycles apart.
REQ-031 Operands changed during BUSY (A0 0xFF→0x00 one cycle after grant, B0=0xFF) → y=0xFF.
REQ-032 rst_n pulsed low at the 4th BUSY cycle → outputs are 0 immediately, no done pulse, and the next request to req=1000 with req=0001 also pending grants 0 first.
REQ-033 Boundary operands: A=0xFF,B=0xFF → y=0xFF; A=0xAA,B=0x55 → y=0x00; after the second transaction y stays 0x00 for ≥20 idle cycles.
REQ-034 WIDTH=2 build, req=0100, A2=2'b11, B2=2'b01 → busy for 2 cycles, y=2'b01, done_id=2.

Source files
------------

// File: rtl/and_share_arb_if.sv
// and_share_arb_if: request/result bundle for the bit-serial shared AND arbiter.
//   req      : 4 request lines, one per requester
//   a_in     : packed operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in     : packed operand B, same packing as a_in
//   gnt      : one-hot grant pulse for the accepted requester
//   busy     : high while the shared AND engine is computing
//   done     : one-cycle result-valid pulse
//   done_id  : index of the requester whose result is on y
//   y        : result a & b of the last completed transaction
// master drives requests/operands; slave (the arbiter) drives results.
interface and_share_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] a_in;
    logic [4*WIDTH-1:0] b_in;
    logic [3:0]         gnt;
    logic               busy;
    logic               done;
    logic [1:0]         done_id;
    logic [WIDTH-1:0]   y;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, done_id, y
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, done_id, y
    );
endinterface

// File: rtl/and_share_arb.sv
// and_share_arb: four requesters share a single 1-bit AND gate. A round-robin
// winner's operands are latched and ANDed one bit per cycle over WIDTH cycles;
// the full result is then published on y with done_id and a one-cycle done.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : and_share_arb_if.slave (req, a_in, b_in in; gnt, busy, done,
//            done_id, y out)
module and_share_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    and_share_arb_if.slave bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       done_id_q, done_id_d;
    logic [1:0]       last_w_q, last_w_d;
    logic [3:0]       gnt_q, gnt_d;

    // Round-robin winner search
    logic       win_found;
    logic [1:0] win;
    logic [1:0] idx;

    always_comb begin
        win_found = 1'b0;
        win       = last_w_q;
        idx       = last_w_q;
        // Start one past the last winner and wrap upward; i == 4 revisits last_w.
        for (int i = 1; i <= 4; i++) begin
            idx = last_w_q + 2'(i);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    // The single shared AND gate and the partial result with this bit merged in.
    logic             and_bit;
    logic [WIDTH-1:0] res_upd;
    logic [31:0]      sel_base;

    always_comb begin
        and_bit          = op_a_q[cnt_q] & op_b_q[cnt_q];
        res_upd          = res_q;
        res_upd[cnt_q]   = and_bit;
        sel_base         = 32'(win) * WIDTH;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        y_d       = y_q;
        done_id_d = done_id_q;
        last_w_d  = last_w_q;
        gnt_d     = 4'b0000;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BUSY;
                    op_a_d   = bus.a_in[sel_base +: WIDTH];
                    op_b_d   = bus.b_in[sel_base +: WIDTH];
                    cnt_d    = '0;
                    res_d    = '0;
                    gnt_d    = 4'b0001 << win;
                    last_w_d = win;
                end
            end
            BUSY: begin
                res_d = res_upd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    y_d       = res_upd;
                    done_id_d = last_w_q;
                end
            end
            DONE: begin
                // Requests are deliberately not sampled here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            y_q       <= '0;
            done_id_q <= 2'd0;
            last_w_q  <= 2'd3; // requester 0 gets first priority
            gnt_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_q     <= res_d;
            y_q       <= y_d;
            done_id_q <= done_id_d;
            last_w_q  <= last_w_d;
            gnt_q     <= gnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == BUSY);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.y       = y_q;

endmodule

// File: tb/tb_and_share_arb.sv
module tb_and_share_arb;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;

    and_share_arb_if #(.WIDTH(8)) bus8 ();
    and_share_arb_if #(.WIDTH(2)) bus2 ();

    and_share_arb #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    and_share_arb #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Waits (bounded) for a grant on the WIDTH=8 instance; no checking here.
    task automatic wait_gnt8(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus8.gnt != 4'b0000) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done8(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus8.gnt !== 4'b0000 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: gnt=%b busy=%b done=%b required 0000/0/0",
                     bus8.gnt, bus8.busy, bus8.done);
        end
        tests++;
        if (bus8.y !== 8'h00 || bus8.done_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: y=%h done_id=%0d required 00/0", bus8.y, bus8.done_id);
        end
        tests++;
        if (bus2.y !== 2'b00 || bus2.busy !== 1'b0 || bus2.gnt !== 4'b0000) begin
            fails++;
            $display("FAIL reset_w2: y=%b busy=%b gnt=%b required 00/0/0000",
                     bus2.y, bus2.busy, bus2.gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int nbusy;
        bus8.a_in = {24'h0, 8'hF0};
        bus8.b_in = {24'h0, 8'h3C};
        bus8.req  = 4'b0001;
        @(negedge clk);
        bus8.req = 4'b0000;
        tests++;
        if (bus8.gnt !== 4'b0001 || bus8.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_gnt: gnt=%b busy=%b required 0001/1", bus8.gnt, bus8.busy);
        end
        nbusy = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (bus8.busy === 1'b1 && bus8.gnt === 4'b0000 && bus8.done === 1'b0) nbusy++;
        end
        tests++;
        if (nbusy != 8) begin
            fails++;
            $display("FAIL single_busy: busy-only cycles=%0d required 8", nbusy);
        end
        @(negedge clk);
        tests++;
        if (bus8.done !== 1'b1 || bus8.busy !== 1'b0 || bus8.gnt !== 4'b0000
            || bus8.y !== 8'h30 || bus8.done_id !== 2'd0) begin
            fails++;
            $display("FAIL single_done: done=%b busy=%b gnt=%b y=%h id=%0d required 1/0/0000/30/0",
                     bus8.done, bus8.busy, bus8.gnt, bus8.y, bus8.done_id);
        end
        @(negedge clk);
        tests++;
        if (bus8.done !== 1'b0 || bus8.y !== 8'h30) begin
            fails++;
            $display("FAIL single_pulse: done=%b y=%h required 0/30", bus8.done, bus8.y);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ya [4];
        logic [3:0] exp_gnt;
        int         last_done;
        bit         ok;
        ya[0] = 8'h30; ya[1] = 8'h0F; ya[2] = 8'h81; ya[3] = 8'h16;
        do_reset();
        bus8.a_in = {8'h77, 8'hC3, 8'h0F, 8'hF0};
        bus8.b_in = {8'h1E, 8'h81, 8'hFF, 8'h3C};
        bus8.req  = 4'b1111;
        last_done = 0;
        for (int t = 0; t < 5; t++) begin
            exp_gnt = 4'b0001 << (t % 4);
            wait_gnt8(ok);
            if (t == 4) bus8.req = 4'b0000;
            tests++;
            if (!ok || bus8.gnt !== exp_gnt) begin
                fails++;
                $display("FAIL rr_gnt%0d: gnt=%b required %b", t, bus8.gnt, exp_gnt);
            end
            wait_done8(ok);
            tests++;
            if (!ok || bus8.done_id !== 2'(t % 4) || bus8.y !== ya[t % 4]) begin
                fails++;
                $display("FAIL rr_done%0d: done=%b id=%0d y=%h required 1/%0d/%h",
                         t, bus8.done, bus8.done_id, bus8.y, t % 4, ya[t % 4]);
            end
            if (t > 0) begin
                tests++;
                if (cyc - last_done != 10) begin
                    fails++;
                    $display("FAIL rr_spacing%0d: spacing=%0d required 10", t, cyc - last_done);
                end
            end
            last_done = cyc;
        end
        bus8.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        bit ok;
        bus8.a_in = {24'h0, 8'hFF};
        bus8.b_in = {24'h0, 8'hFF};
        bus8.req  = 4'b0001;
        wait_gnt8(ok);
        tests++;
        if (!ok || bus8.gnt !== 4'b0001) begin
            fails++;
            $display("FAIL opchg_gnt: gnt=%b required 0001", bus8.gnt);
        end
        bus8.req = 4'b0000;
        @(negedge clk);
        bus8.a_in = {24'h0, 8'h00};
        wait_done8(ok);
        tests++;
        if (!ok || bus8.y !== 8'hFF) begin
            fails++;
            $display("FAIL opchg_y: done=%b y=%h required 1/ff", bus8.done, bus8.y);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        int ndone;
        bus8.a_in = {8'hFF, 16'h0, 8'h5A};
        bus8.b_in = {8'hFF, 16'h0, 8'h0F};
        bus8.req  = 4'b1000;
        wait_gnt8(ok);
        tests++;
        if (!ok || bus8.gnt !== 4'b1000) begin
            fails++;
            $display("FAIL rstmid_gnt: gnt=%b required 1000", bus8.gnt);
        end
        bus8.req = 4'b0000;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus8.gnt !== 4'b0000 || bus8.busy !== 1'b0 || bus8.done !== 1'b0
            || bus8.y !== 8'h00 || bus8.done_id !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_out: gnt=%b busy=%b done=%b y=%h id=%0d required all zero",
                     bus8.gnt, bus8.busy, bus8.done, bus8.y, bus8.done_id);
        end
        @(negedge clk);
        if (bus8.done) ndone++;
        rst_n    = 1'b1;
        bus8.req = 4'b1001;
        @(negedge clk);
        tests++;
        if (bus8.gnt !== 4'b0001 || ndone != 0) begin
            fails++;
            $display("FAIL rstmid_prio: gnt=%b dones=%0d required 0001/0", bus8.gnt, ndone);
        end
        bus8.req = 4'b0000;
        wait_done8(ok);
        tests++;
        if (!ok || bus8.done_id !== 2'd0 || bus8.y !== 8'h0A) begin
            fails++;
            $display("FAIL rstmid_res: id=%0d y=%h required 0/0a", bus8.done_id, bus8.y);
        end
    endtask

    task automatic test_boundary();
        bit ok;
        int nbad;
        bus8.a_in = {24'h0, 8'hFF};
        bus8.b_in = {24'h0, 8'hFF};
        bus8.req  = 4'b0001;
        wait_gnt8(ok);
        bus8.req = 4'b0000;
        wait_done8(ok);
        tests++;
        if (!ok || bus8.y !== 8'hFF) begin
            fails++;
            $display("FAIL bound_ff: y=%h required ff", bus8.y);
        end
        bus8.a_in = {24'h0, 8'hAA};
        bus8.b_in = {24'h0, 8'h55};
        bus8.req  = 4'b0001;
        wait_gnt8(ok);
        bus8.req = 4'b0000;
        wait_done8(ok);
        tests++;
        if (!ok || bus8.y !== 8'h00) begin
            fails++;
            $display("FAIL bound_aa55: y=%h required 00", bus8.y);
        end
        nbad = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (bus8.y !== 8'h00 || bus8.done !== 1'b0 || bus8.busy !== 1'b0) nbad++;
        end
        tests++;
        if (nbad != 0) begin
            fails++;
            $display("FAIL bound_hold: bad idle cycles=%0d required 0", nbad);
        end
    endtask

    task automatic test_width2();
        bus2.a_in = 8'b00_11_00_00;
        bus2.b_in = 8'b00_01_00_00;
        bus2.req  = 4'b0100;
        @(negedge clk);
        bus2.req = 4'b0000;
        tests++;
        if (bus2.gnt !== 4'b0100 || bus2.busy !== 1'b1) begin
            fails++;
            $display("FAIL w2_gnt: gnt=%b busy=%b required 0100/1", bus2.gnt, bus2.busy);
        end
        @(negedge clk);
        tests++;
        if (bus2.busy !== 1'b1 || bus2.gnt !== 4'b0000 || bus2.done !== 1'b0) begin
            fails++;
            $display("FAIL w2_busy2: busy=%b gnt=%b done=%b required 1/0000/0",
                     bus2.busy, bus2.gnt, bus2.done);
        end
        @(negedge clk);
        tests++;
        if (bus2.done !== 1'b1 || bus2.busy !== 1'b0 || bus2.y !== 2'b01
            || bus2.done_id !== 2'd2) begin
            fails++;
            $display("FAIL w2_done: done=%b busy=%b y=%b id=%0d required 1/0/01/2",
                     bus2.done, bus2.busy, bus2.y, bus2.done_id);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus8.req  = 4'b0000;
        bus8.a_in = '0;
        bus8.b_in = '0;
        bus2.req  = 4'b0000;
        bus2.a_in = '0;
        bus2.b_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single();
        test_round_robin();
        test_operand_change();
        test_reset_mid_busy();
        test_boundary();
        test_width2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
